p_clic_ctrl: RTL and testbench
==============================

P_CLIC_CTRL -- requirements
Module: p_clic_ctrl

Interface
REQ-001 Parameter NrSources, default 4, number of interrupt sources; SHALL match the arbiter it serves.
REQ-002 Parameter PrioWidth, default 3, priority/threshold width in bits.
REQ-003 Parameter Depth, default 4, nesting depth of the threshold stack (>=1).
REQ-004 Derived SrcWidth = $clog2(NrSources); DepthWidth = $clog2(Depth+1).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 index  input  SrcWidth  winning source from arbiter.
REQ-008 is_interrupt  input  1  arbiter winner exceeds current threshold.
REQ-009 win_prio  input  PrioWidth  priority of the winning source.
REQ-010 irq_ready  input  1  core accepts the offered interrupt.
REQ-011 complete  input  1  core signals handler return (one-cycle pulse).
REQ-012 t  output  PrioWidth  current threshold, fed back to arbiter.
REQ-013 irq_valid  output  1  interrupt offered to core.
REQ-014 irq_id  output  SrcWidth  source id of offered interrupt.
REQ-015 irq_level  output  PrioWidth  priority of offered interrupt.
REQ-016 clr  output  NrSources  one-hot pending-clear pulse.
REQ-017 depth  output  DepthWidth  number of saved thresholds.
REQ-018 err  output  1  one-cycle pulse on complete with empty stack.

Function
REQ-019 States SHALL be IDLE and OFFER; state, t, depth, irq_* and stack are registers; clr and err are registered one-cycle pulses.
REQ-020 IDLE: if is_interrupt=1 and depth<Depth, latch index->irq_id, win_prio->irq_level, go OFFER; irq_valid=1 from next cycle (1-cycle latency).
REQ-021 IDLE with depth==Depth (stack full): is_interrupt SHALL be ignored; no offer.
REQ-022 OFFER: irq_valid=1; irq_id and irq_level SHALL remain stable until accepted, independent of arbiter inputs.
REQ-023 Take = irq_valid & irq_ready: push t to stack[depth], depth+1, t <= irq_level, clr[irq_id] pulses 1 next cycle, irq_valid=0 next cycle, go IDLE.
REQ-024 After take, controller SHALL not re-offer before the cycle following the clr pulse (one IDLE cycle minimum).
REQ-025 complete with depth>0 (no take same cycle): t <= stack[depth-1], depth-1; state unchanged.
REQ-026 complete with depth==0: t and depth unchanged; err pulses 1 next cycle.
REQ-027 complete and take in same cycle with depth>0: net stack unchanged, depth unchanged, t <= irq_level, clr pulse as REQ-023.
REQ-028 complete and take in same cycle with depth==0: take per REQ-023, err pulse per REQ-026.
REQ-029 irq_ready while irq_valid=0 SHALL have no effect.
REQ-030 Threshold comparisons are performed by the arbiter; this block does no arithmetic on priorities other than storage.
REQ-031 Stack SHALL be LIFO; entries above depth are don't-care.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE, t=0, depth=0, irq_valid=0, irq_id=0, irq_level=0, clr=0, err=0.
REQ-033 Reset SHALL take priority over every other input in the same cycle, including mid-offer and mid-nesting; stack contents discarded.

Verification
REQ-034 Reset, is_interrupt=1, index=2, win_prio=3, irq_ready=1 held -> irq_valid=1, irq_id=2, irq_level=3 one cycle later; next cycle t=3, depth=1, clr=4'b0100 for one cycle.
REQ-035 Nesting: take prio 2, then prio 5, then complete x2 -> t sequence 0,2,5,2,0; depth 0,1,2,1,0; err never asserted.
REQ-036 Depth=4 filled with prios 1..4, is_interrupt=1 win_prio=7 -> irq_valid stays 0 until a complete; then offer within 1 cycle.
REQ-037 OFFER with irq_ready=0, index/win_prio change 1->3 and 2->6 -> irq_id and irq_level remain original values until take.
REQ-038 complete with depth=0 -> err=1 for exactly one cycle, t=0, depth=0; simultaneous complete+take at depth=1, t=2, offered prio 6 -> t=6, depth=1, stack top still 0.
REQ-039 rst asserted during OFFER at depth=2 -> next cycle all outputs per REQ-032.

Source files
------------

// File: rtl/p_clic_ctrl.sv
// Interrupt offer controller with a nesting threshold stack.
// Offers the arbiter's winner to the core, pushes and pops the threshold on take/complete.
module p_clic_ctrl #(
    parameter int NrSources  = 4,
    parameter int PrioWidth  = 3,
    parameter int Depth      = 4,
    localparam int SrcWidth   = (NrSources > 1) ? $clog2(NrSources) : 1,
    localparam int DepthWidth = $clog2(Depth + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SrcWidth-1:0]   index,
    input  logic                  is_interrupt,
    input  logic [PrioWidth-1:0]  win_prio,
    input  logic                  irq_ready,
    input  logic                  complete,
    output logic [PrioWidth-1:0]  t,
    output logic                  irq_valid,
    output logic [SrcWidth-1:0]   irq_id,
    output logic [PrioWidth-1:0]  irq_level,
    output logic [NrSources-1:0]  clr,
    output logic [DepthWidth-1:0] depth,
    output logic                  err
);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e                state_q, state_d;
    logic [PrioWidth-1:0]  t_q, t_d;
    logic [DepthWidth-1:0] depth_q, depth_d;
    logic                  valid_q, valid_d;
    logic [SrcWidth-1:0]   id_q, id_d;
    logic [PrioWidth-1:0]  level_q, level_d;
    logic [NrSources-1:0]  clr_q, clr_d;
    logic                  err_q, err_d;
    logic [PrioWidth-1:0]  stack_q [Depth];
    logic [PrioWidth-1:0]  stack_d [Depth];

    logic                  take;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic [PrioWidth-1:0]  top;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        depth_d = depth_q;
        valid_d = valid_q;
        id_d    = id_q;
        level_d = level_q;
        clr_d   = '0;
        err_d   = 1'b0;
        stack_d = stack_q;
        top     = '0;

        take  = valid_q & irq_ready;
        empty = (depth_q == '0);
        full  = (depth_q == DepthWidth'(Depth));
        pop   = complete & ~empty;

        for (int i = 0; i < Depth; i++) begin
            if (depth_q == DepthWidth'(i + 1)) top = stack_q[i];
        end

        case (state_q)
            IDLE: begin
                if (is_interrupt && !full) begin
                    state_d = OFFER;
                    valid_d = 1'b1;
                    id_d    = index;
                    level_d = win_prio;
                end
            end
            OFFER: begin
                if (take) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    clr_d   = NrSources'(1) << id_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // A take in the same cycle as a pop replaces the top in place, so the stack is left as-is.
        if (take) begin
            t_d = level_q;
            if (!pop) begin
                for (int i = 0; i < Depth; i++) begin
                    if (depth_q == DepthWidth'(i)) stack_d[i] = t_q;
                end
                depth_d = depth_q + DepthWidth'(1);
            end
        end else if (pop) begin
            t_d     = top;
            depth_d = depth_q - DepthWidth'(1);
        end

        if (complete && empty) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            depth_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            level_q <= '0;
            clr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            depth_q <= depth_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            level_q <= level_d;
            clr_q   <= clr_d;
            err_q   <= err_d;
        end
    end

    // Entries above depth are never read, so the stack needs no reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign t         = t_q;
    assign depth     = depth_q;
    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign irq_level = level_q;
    assign clr       = clr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_p_clic_ctrl.sv
// Bench for p_clic_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_p_clic_ctrl;

    localparam int NrSources = 4;
    localparam int PrioWidth = 3;
    localparam int Depth     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] index = '0;
    logic       is_interrupt = 1'b0;
    logic [2:0] win_prio = '0;
    logic       irq_ready = 1'b0;
    logic       complete = 1'b0;
    logic [2:0] t;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [2:0] irq_level;
    logic [3:0] clr;
    logic [2:0] depth;
    logic       err;

    int ncmp  = 0;
    int nfail = 0;

    p_clic_ctrl #(.NrSources(NrSources), .PrioWidth(PrioWidth), .Depth(Depth)) dut (
        .clk(clk), .rst(rst), .index(index), .is_interrupt(is_interrupt),
        .win_prio(win_prio), .irq_ready(irq_ready), .complete(complete),
        .t(t), .irq_valid(irq_valid), .irq_id(irq_id), .irq_level(irq_level),
        .clr(clr), .depth(depth), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: offer flag, latched id/level, threshold, and a queue as the LIFO.
    bit         m_offer;
    logic [1:0] m_id;
    logic [2:0] m_level;
    logic [2:0] m_t;
    logic [2:0] m_stack[$];
    logic [3:0] m_clr;
    bit         m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_offer = 0; m_id = 0; m_level = 0; m_t = 0;
            m_stack.delete(); m_clr = 0; m_err = 0;
        end else begin
            int  n_before;
            bit  tk;
            n_before = m_stack.size();
            tk       = m_offer && irq_ready;
            m_clr    = tk ? (4'b0001 << m_id) : 4'b0000;
            m_err    = complete && (n_before == 0);
            if (tk && complete && n_before > 0) begin
                m_t = m_level;
            end else if (tk) begin
                m_stack.push_back(m_t);
                m_t = m_level;
            end else if (complete && n_before > 0) begin
                m_t = m_stack.pop_back();
            end
            if (tk) begin
                m_offer = 0;
            end else if (!m_offer && is_interrupt && n_before < Depth) begin
                m_offer = 1; m_id = index; m_level = win_prio;
            end
        end
        #1;
        chk("model_valid", irq_valid, m_offer);
        chk("model_id",    irq_id,    m_id);
        chk("model_level", irq_level, m_level);
        chk("model_t",     t,         m_t);
        chk("model_depth", depth,     m_stack.size());
        chk("model_clr",   clr,       m_clr);
        chk("model_err",   err,       m_err);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; is_interrupt = 0; irq_ready = 0; complete = 0; index = 0; win_prio = 0;
        cyc(1);
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_t"}, t, 0);
        chk({nm, "_depth"}, depth, 0);
        chk({nm, "_valid"}, irq_valid, 0);
        chk({nm, "_id"}, irq_id, 0);
        chk({nm, "_level"}, irq_level, 0);
        chk({nm, "_clr"}, clr, 0);
        chk({nm, "_err"}, err, 0);
    endtask

    initial begin
        cyc(2);
        chk_reset_state("reset");
        rst = 1'b0;

        // Basic offer and take
        is_interrupt = 1; index = 2; win_prio = 3; irq_ready = 1;
        cyc(1);
        chk("basic_valid", irq_valid, 1);
        chk("basic_id", irq_id, 2);
        chk("basic_level", irq_level, 3);
        cyc(1);
        chk("basic_t", t, 3);
        chk("basic_depth", depth, 1);
        chk("basic_clr", clr, 4'b0100);
        chk("basic_valid_drop", irq_valid, 0);
        cyc(1);
        chk("basic_clr_once", clr, 0);

        // Nesting: prio 2 then 5, then two completes
        do_reset();
        is_interrupt = 1; index = 1; win_prio = 2; irq_ready = 1;
        cyc(1);
        is_interrupt = 0;
        cyc(1);
        chk("nest_t1", t, 2);
        chk("nest_d1", depth, 1);
        is_interrupt = 1; index = 3; win_prio = 5;
        cyc(2);
        chk("nest_t2", t, 5);
        chk("nest_d2", depth, 2);
        is_interrupt = 0; irq_ready = 0; complete = 1;
        cyc(1);
        chk("nest_t3", t, 2);
        chk("nest_d3", depth, 1);
        cyc(1);
        chk("nest_t4", t, 0);
        chk("nest_d4", depth, 0);
        complete = 0;

        // Fill the stack with prios 1..4, then a pending prio 7 is held off
        do_reset();
        is_interrupt = 1; irq_ready = 1;
        for (int p = 1; p <= 4; p++) begin
            win_prio = 3'(p); index = 2'(p % 4);
            cyc(2);
        end
        chk("full_t", t, 4);
        chk("full_depth", depth, 4);
        win_prio = 7; index = 1;
        cyc(3);
        chk("full_no_offer", irq_valid, 0);
        complete = 1;
        cyc(1);
        complete = 0; irq_ready = 0;
        chk("full_pop_t", t, 3);
        chk("full_pop_depth", depth, 3);
        cyc(1);
        chk("full_offer", irq_valid, 1);
        chk("full_offer_level", irq_level, 7);

        // Offer stays stable while arbiter inputs move
        do_reset();
        is_interrupt = 1; index = 1; win_prio = 2;
        cyc(1);
        index = 3; win_prio = 6;
        cyc(2);
        chk("stable_id", irq_id, 1);
        chk("stable_level", irq_level, 2);
        irq_ready = 1; is_interrupt = 0;
        cyc(1);
        chk("stable_t", t, 2);
        chk("stable_clr", clr, 4'b0010);
        irq_ready = 0;

        // Complete on empty stack, then simultaneous complete and take at depth 1
        do_reset();
        complete = 1;
        cyc(1);
        complete = 0;
        chk("empty_err", err, 1);
        chk("empty_t", t, 0);
        chk("empty_depth", depth, 0);
        cyc(1);
        chk("empty_err_once", err, 0);
        is_interrupt = 1; index = 0; win_prio = 2; irq_ready = 1;
        cyc(2);
        chk("sim_pre_t", t, 2);
        win_prio = 6; index = 3; irq_ready = 0;
        cyc(1);
        chk("sim_offer_level", irq_level, 6);
        is_interrupt = 0; irq_ready = 1; complete = 1;
        cyc(1);
        chk("sim_t", t, 6);
        chk("sim_depth", depth, 1);
        chk("sim_clr", clr, 4'b1000);
        irq_ready = 0;
        cyc(1);
        complete = 0;
        chk("sim_top_t", t, 0);
        chk("sim_top_depth", depth, 0);

        // Take and complete together at depth 0
        do_reset();
        is_interrupt = 1; index = 2; win_prio = 5;
        cyc(1);
        is_interrupt = 0; irq_ready = 1; complete = 1;
        cyc(1);
        irq_ready = 0; complete = 0;
        chk("d0_t", t, 5);
        chk("d0_depth", depth, 1);
        chk("d0_err", err, 1);
        chk("d0_clr", clr, 4'b0100);

        // Reset during an offer at depth 2
        do_reset();
        is_interrupt = 1; irq_ready = 1; index = 1; win_prio = 1;
        cyc(2);
        win_prio = 4;
        cyc(2);
        irq_ready = 0; win_prio = 6;
        cyc(1);
        chk("rst_pre_depth", depth, 2);
        chk("rst_pre_valid", irq_valid, 1);
        rst = 1; complete = 1; irq_ready = 1;
        cyc(1);
        chk_reset_state("rst_mid");
        rst = 0; complete = 0; irq_ready = 0; is_interrupt = 0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
        $finish;
    end

endmodule
